codedlock_seq: RTL

CODEDLOCK_SEQ -- requirements
Module: codedlock_seq

---
 rtl/codedlock_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/codedlock_seq.sv
// Digit-by-digit code lock: IDLE/ENTRY collect CODE_LEN digits, then OPEN (led1) or FAIL (led2).
// Define CODEDLOCK_LOCKOUT_EN to add the failure counter and the timed LOCKOUT state.
module codedlock_seq #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               digit_valid,
  input  logic [DIGIT_W-1:0]                 digit,
  input  logic [CODE_LEN*DIGIT_W-1:0]        code_in,
  input  logic                               clear,
  output logic                               led1,
  output logic                               led2,
  output logic [$clog2(CODE_LEN+1)-1:0]      entry_cnt,
  output logic                               locked_out
);

  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int TMAX   = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TIM_W  = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_mis, w_mis_nxt;
  logic [TIM_W-1:0]   r_timer, w_timer_nxt;
  logic               r_led1, r_led2;
  logic [CODE_LEN*DIGIT_W-1:0] w_code_sh;
  logic               w_digit_bad;
  logic               w_last;

  // The expected digit is re-read from code_in on every accepted strobe.
  assign w_code_sh   = code_in >> (DIGIT_W * (CODE_LEN - 1 - int'(r_cnt)));
  assign w_digit_bad = (digit != w_code_sh[DIGIT_W-1:0]);
  assign w_last      = (r_cnt == CNT_W'(CODE_LEN - 1));

`ifdef CODEDLOCK_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  logic [FAIL_W-1:0]  r_fails, w_fails_nxt;
  logic               r_locked;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mis_nxt   = r_mis;
    w_timer_nxt = r_timer;
`ifdef CODEDLOCK_LOCKOUT_EN
    w_fails_nxt = r_fails;
`endif
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_mis_nxt   = 1'b0;
        end else if (digit_valid) begin
          if (w_last) begin
            w_cnt_nxt = '0;
            w_mis_nxt = 1'b0;
            if (r_mis || w_digit_bad) begin
              w_state_nxt = S_FAIL;
`ifdef CODEDLOCK_LOCKOUT_EN
              if (r_fails != FAIL_W'(MAX_TRIES)) w_fails_nxt = r_fails + 1'b1;
`endif
            end else begin
              w_state_nxt = S_OPEN;
              w_timer_nxt = TIM_W'(OPEN_CYCLES - 1);
`ifdef CODEDLOCK_LOCKOUT_EN
              w_fails_nxt = '0;
`endif
            end
          end else begin
            w_state_nxt = S_ENTRY;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_mis_nxt   = r_mis || w_digit_bad;
          end
        end
      end
      S_OPEN: begin
        if (clear || r_timer == '0) w_state_nxt = S_IDLE;
        else                        w_timer_nxt = r_timer - 1'b1;
      end
      S_FAIL: begin
        w_state_nxt = S_IDLE;
`ifdef CODEDLOCK_LOCKOUT_EN
        if (r_fails == FAIL_W'(MAX_TRIES)) begin
          w_state_nxt = S_LOCKOUT;
          w_timer_nxt = TIM_W'(LOCK_CYCLES - 1);
        end
`endif
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
`ifdef CODEDLOCK_LOCKOUT_EN
          w_fails_nxt = '0;
`endif
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Indicators are registered from the next state so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mis   <= 1'b0;
      r_timer <= '0;
      r_led1  <= 1'b0;
      r_led2  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mis   <= w_mis_nxt;
      r_timer <= w_timer_nxt;
      r_led1  <= (w_state_nxt == S_OPEN);
      r_led2  <= (w_state_nxt == S_FAIL) || (w_state_nxt == S_LOCKOUT);
    end
  end

`ifdef CODEDLOCK_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fails  <= '0;
      r_locked <= 1'b0;
    end else begin
      r_fails  <= w_fails_nxt;
      r_locked <= (w_state_nxt == S_LOCKOUT);
    end
  end
  assign locked_out = r_locked;
`else
  assign locked_out = 1'b0;
`endif

  assign led1      = r_led1;
  assign led2      = r_led2;
  assign entry_cnt = r_cnt;

endmodule
